alu_fp_arbiter: RTL and testbench

//   Shares one alu_fixed_point instance (signed Qm.n add/sub/mul/div) between NUM_REQ requesters.

---
 rtl/alu_fp_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_alu_fp_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_fp_arbiter.sv
// Round-robin arbiter sharing one signed fixed-point ALU among NUM_REQ requesters.
// Operands and results are registered; responses carry the requester ID and feed a saturating error counter.

module alu_fixed_point #(
  parameter int INT_WIDTH  = 4,
  parameter int FRAC_WIDTH = 4
) (
  input  logic signed [INT_WIDTH+FRAC_WIDTH:0] a,
  input  logic signed [INT_WIDTH+FRAC_WIDTH:0] b,
  input  logic        [1:0]                    op,
  output logic        [INT_WIDTH+FRAC_WIDTH:0] result,
  output logic                                 overflow,
  output logic                                 underflow
);
  localparam int DW = INT_WIDTH + FRAC_WIDTH + 1;
  localparam int WW = 2 * DW + FRAC_WIDTH;
  localparam logic signed [DW-1:0] MAX_N = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_N = {1'b1, {(DW-1){1'b0}}};

  logic signed [WW-1:0] a_x;
  logic signed [WW-1:0] b_x;
  logic signed [WW-1:0] full;
  logic                 div_zero;

  // Exact result is formed wide, then truncated; overflow/underflow mean above max / below min.
  always_comb begin
    a_x      = WW'(a);
    b_x      = WW'(b);
    div_zero = (op == 2'b11) && (b == '0);
    full     = '0;
    case (op)
      2'b00:   full = a_x + b_x;
      2'b01:   full = a_x - b_x;
      2'b10:   full = (a_x * b_x) >>> FRAC_WIDTH;
      default: if (!div_zero) full = (a_x <<< FRAC_WIDTH) / b_x;
    endcase
    result    = full[DW-1:0];
    overflow  = div_zero || (full > WW'(MAX_N));
    underflow = !div_zero && (full < WW'(MIN_N));
  end
endmodule

module alu_fp_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int INT_WIDTH     = 4,
  parameter int FRAC_WIDTH    = 4,
  parameter int DATA_WIDTH    = INT_WIDTH + FRAC_WIDTH + 1,
  parameter int ID_WIDTH      = $clog2(NUM_REQ),
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]          req_op,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          rsp_overflow,
  output logic                          rsp_underflow,
  input  logic                          err_clr,
  output logic [ERR_CNT_WIDTH-1:0]      err_count
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [ID_WIDTH-1:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]      op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]      op_b_q, op_b_d;
  logic [1:0]                 op_code_q, op_code_d;
  logic [ID_WIDTH-1:0]        op_id_q, op_id_d;
  logic [DATA_WIDTH-1:0]      rsp_result_q, rsp_result_d;
  logic                       rsp_ovf_q, rsp_ovf_d;
  logic                       rsp_unf_q, rsp_unf_d;
  logic [ID_WIDTH-1:0]        rsp_id_q, rsp_id_d;
  logic [ERR_CNT_WIDTH-1:0]   err_count_q, err_count_d;

  logic                       grant_found;
  logic [ID_WIDTH-1:0]        grant_idx;
  logic [DATA_WIDTH-1:0]      win_a;
  logic [DATA_WIDTH-1:0]      win_b;
  logic [1:0]                 win_op;
  logic [DATA_WIDTH-1:0]      alu_result;
  logic                       alu_ovf;
  logic                       alu_unf;

  // Rotating scan as two fixed-order passes: indices >= rr_ptr first, then the wrap-around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (ID_WIDTH'(i) >= rr_ptr_q)) begin
        grant_found = 1'b1;
        grant_idx   = ID_WIDTH'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = ID_WIDTH'(i);
      end
    end
  end

  always_comb begin
    win_a  = '0;
    win_b  = '0;
    win_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_WIDTH'(i) == grant_idx) begin
        win_a  = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        win_b  = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        win_op = req_op[i*2 +: 2];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == ST_IDLE) && grant_found) req_ready[grant_idx] = 1'b1;
  end

  alu_fixed_point #(
    .INT_WIDTH  (INT_WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_alu (
    .a         (op_a_q),
    .b         (op_b_q),
    .op        (op_code_q),
    .result    (alu_result),
    .overflow  (alu_ovf),
    .underflow (alu_unf)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_code_d    = op_code_q;
    op_id_d      = op_id_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_unf_d    = rsp_unf_q;
    rsp_id_d     = rsp_id_q;
    err_count_d  = err_count_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          op_a_d    = win_a;
          op_b_d    = win_b;
          op_code_d = win_op;
          op_id_d   = grant_idx;
          rr_ptr_d  = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + ID_WIDTH'(1);
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_ovf_d    = alu_ovf;
        rsp_unf_d    = alu_unf;
        rsp_id_d     = op_id_q;
        state_d      = ST_RESP;
        if ((alu_ovf || alu_unf) && (err_count_q != '1))
          err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (err_clr) err_count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_code_q    <= '0;
      op_id_q      <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_unf_q    <= 1'b0;
      rsp_id_q     <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_code_q    <= op_code_d;
      op_id_q      <= op_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_unf_q    <= rsp_unf_d;
      rsp_id_q     <= rsp_id_d;
      err_count_q  <= err_count_d;
    end
  end

  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_id        = rsp_id_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_overflow  = rsp_ovf_q;
  assign rsp_underflow = rsp_unf_q;
  assign err_count     = err_count_q;
endmodule

// File: tb/tb_alu_fp_arbiter.sv
// Directed bench for alu_fp_arbiter with the Q4.4 defaults and hand-computed results.

module tb_alu_fp_arbiter;
  localparam int N  = 4;
  localparam int DW = 9;
  localparam int IW = 2;
  localparam int EW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a = '0;
  logic [N*DW-1:0] req_b = '0;
  logic [N*2-1:0]  req_op = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_result;
  logic            rsp_overflow;
  logic            rsp_underflow;
  logic            err_clr = 1'b0;
  logic [EW-1:0]   err_count;

  int checks = 0;
  int fails  = 0;

  alu_fp_arbiter #(
    .NUM_REQ       (N),
    .INT_WIDTH     (4),
    .FRAC_WIDTH    (4),
    .DATA_WIDTH    (DW),
    .ID_WIDTH      (IW),
    .ERR_CNT_WIDTH (EW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_op        (req_op),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .rsp_overflow  (rsp_overflow),
    .rsp_underflow (rsp_underflow),
    .err_clr       (err_clr),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  // Issue one op on port id and return at the negedge where the response should be valid.
  // acc: accepted within budget; lat: rsp_valid low one cycle after accept, high the cycle after.
  task automatic do_op(input int id, input logic [1:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input bit clr_in_exec,
                       output bit acc, output bit lat);
    int waited;
    @(negedge clk);
    req_a[id*DW +: DW] = a;
    req_b[id*DW +: DW] = b;
    req_op[id*2 +: 2]  = op;
    req_valid[id[1:0]] = 1'b1;
    acc    = 1'b0;
    lat    = 1'b0;
    waited = 0;
    #1;
    while (!acc && waited < 20) begin
      if (req_ready[id[1:0]] === 1'b1) acc = 1'b1;
      else begin
        @(negedge clk);
        #1;
        waited++;
      end
    end
    if (acc) begin
      @(posedge clk);
      @(negedge clk);
      req_valid[id[1:0]] = 1'b0;
      if (clr_in_exec) err_clr = 1'b1;
      lat = (rsp_valid === 1'b0);
      @(negedge clk);
      err_clr = 1'b0;
      lat = lat && (rsp_valid === 1'b1);
    end else begin
      req_valid[id[1:0]] = 1'b0;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow, err_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b id=%0d res=%h ovf=%b unf=%b err=%0d expected all 0",
               rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow, err_count);
    end
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    bit acc, lat;
    do_op(0, 2'b00, 9'h018, 9'h024, 1'b0, acc, lat);
    checks++; if (!acc) begin fails++; $display("FAIL add_accept: got no grant expected grant to req 0"); end
    checks++; if (!lat) begin fails++; $display("FAIL add_latency: got rsp_valid timing wrong expected valid 2 cycles after accept"); end
    checks++; if (rsp_result !== 9'h03C) begin fails++; $display("FAIL add_result: got %h expected 03c", rsp_result); end
    checks++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL add_id: got %0d expected 0", rsp_id); end
    checks++; if ({rsp_overflow, rsp_underflow} !== 2'b00) begin fails++; $display("FAIL add_flags: got %b%b expected 00", rsp_overflow, rsp_underflow); end
    release_rsp();
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL add_rsp_drop: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_mul();
    bit acc, lat;
    do_op(2, 2'b10, 9'h018, 9'h020, 1'b0, acc, lat);
    checks++; if (!(acc && lat)) begin fails++; $display("FAIL mul_handshake: got acc=%b lat=%b expected 1 1", acc, lat); end
    checks++; if (rsp_result !== 9'h030) begin fails++; $display("FAIL mul_result: got %h expected 030", rsp_result); end
    checks++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL mul_id: got %0d expected 2", rsp_id); end
    checks++; if (err_count !== 8'd0) begin fails++; $display("FAIL mul_err_count: got %0d expected 0", err_count); end
    release_rsp();
    // -1.5 * 2.0 = -3.0
    do_op(1, 2'b10, 9'h1E8, 9'h020, 1'b0, acc, lat);
    checks++; if ({rsp_result, rsp_overflow, rsp_underflow} !== {9'h1D0, 2'b00}) begin
      fails++; $display("FAIL mul_neg: got %h %b%b expected 1d0 00", rsp_result, rsp_overflow, rsp_underflow);
    end
    release_rsp();
  endtask

  task automatic test_errors();
    bit acc, lat;
    do_op(1, 2'b11, 9'h018, 9'h000, 1'b0, acc, lat);
    checks++; if ({rsp_result, rsp_overflow, rsp_underflow} !== {9'h000, 2'b10}) begin
      fails++; $display("FAIL div_zero: got %h %b%b expected 000 10", rsp_result, rsp_overflow, rsp_underflow);
    end
    checks++; if (err_count !== 8'd1) begin fails++; $display("FAIL div_zero_err: got %0d expected 1", err_count); end
    release_rsp();
    do_op(1, 2'b00, 9'h0FF, 9'h010, 1'b0, acc, lat);
    checks++; if ({rsp_result, rsp_overflow, rsp_underflow} !== {9'h10F, 2'b10}) begin
      fails++; $display("FAIL add_ovf: got %h %b%b expected 10f 10", rsp_result, rsp_overflow, rsp_underflow);
    end
    checks++; if (err_count !== 8'd2) begin fails++; $display("FAIL add_ovf_err: got %0d expected 2", err_count); end
    release_rsp();
    // -16.0 + -1.0 falls below the minimum
    do_op(3, 2'b00, 9'h100, 9'h1F0, 1'b0, acc, lat);
    checks++; if ({rsp_result, rsp_overflow, rsp_underflow} !== {9'h0F0, 2'b01}) begin
      fails++; $display("FAIL add_unf: got %h %b%b expected 0f0 01", rsp_result, rsp_overflow, rsp_underflow);
    end
    checks++; if (err_count !== 8'd3) begin fails++; $display("FAIL add_unf_err: got %0d expected 3", err_count); end
    release_rsp();
    // 1.5 / 2.0 = 0.75
    do_op(0, 2'b11, 9'h018, 9'h020, 1'b0, acc, lat);
    checks++; if ({rsp_result, rsp_overflow, rsp_underflow, err_count} !== {9'h00C, 2'b00, 8'd3}) begin
      fails++; $display("FAIL div_ok: got %h %b%b err=%0d expected 00c 00 err=3", rsp_result, rsp_overflow, rsp_underflow, err_count);
    end
    release_rsp();
    // 1.5 - 2.25 = -0.75
    do_op(2, 2'b01, 9'h018, 9'h024, 1'b0, acc, lat);
    checks++; if ({rsp_result, rsp_overflow, rsp_underflow, rsp_id} !== {9'h1F4, 2'b00, 2'd2}) begin
      fails++; $display("FAIL sub_neg: got %h %b%b id=%0d expected 1f4 00 id=2", rsp_result, rsp_overflow, rsp_underflow, rsp_id);
    end
    release_rsp();
  endtask

  task automatic test_err_clr();
    bit acc, lat;
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_count !== 8'd0) begin fails++; $display("FAIL err_clr_idle: got %0d expected 0", err_count); end
    do_op(0, 2'b00, 9'h0FF, 9'h0FF, 1'b1, acc, lat);
    checks++; if ({rsp_overflow, err_count} !== {1'b1, 8'd0}) begin
      fails++; $display("FAIL err_clr_priority: got ovf=%b err=%0d expected ovf=1 err=0", rsp_overflow, err_count);
    end
    release_rsp();
    do_op(0, 2'b00, 9'h0FF, 9'h0FF, 1'b0, acc, lat);
    checks++; if (err_count !== 8'd1) begin fails++; $display("FAIL err_after_clr: got %0d expected 1", err_count); end
    release_rsp();
  endtask

  task automatic test_saturation();
    bit acc, lat;
    int n_acc;
    n_acc = 0;
    for (int i = 0; i < 260; i++) begin
      do_op(i % 4, 2'b00, 9'h0FF, 9'h0FF, 1'b0, acc, lat);
      if (acc && lat) n_acc++;
      release_rsp();
    end
    checks++; if (n_acc != 260) begin fails++; $display("FAIL sat_handshakes: got %0d expected 260", n_acc); end
    checks++; if (err_count !== 8'hFF) begin fails++; $display("FAIL sat_count: got %0d expected 255", err_count); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    req_valid = '1;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL rr_ready_in_reset: got %b expected 0000", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (req_ready !== (4'b0001 << order[k])) begin
        fails++; $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, 4'b0001 << order[k]);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IW'(order[k])) begin
        fails++; $display("FAIL rr_rsp_id_%0d: got valid=%b id=%0d expected valid=1 id=%0d", k, rsp_valid, rsp_id, order[k]);
      end
      @(negedge clk);
      #1;
    end
    req_valid = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL rr_sparse_first: got %b expected 0010", req_ready); end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL rr_sparse_second: got %b expected 1000", req_ready); end
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rr_drain: got rsp_valid=%b expected 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    bit acc, lat;
    bit stable;
    do_op(3, 2'b01, 9'h020, 9'h018, 1'b0, acc, lat);
    checks++; if ({acc, lat, rsp_result, rsp_id} !== {2'b11, 9'h008, 2'd3}) begin
      fails++; $display("FAIL bp_first: got acc=%b lat=%b res=%h id=%0d expected 1 1 008 3", acc, lat, rsp_result, rsp_id);
    end
    req_a[0 +: DW] = 9'h010;
    req_b[0 +: DW] = 9'h010;
    req_op[1:0] = 2'b00;
    req_valid[0] = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_result !== 9'h008 || rsp_id !== 2'd3 ||
          rsp_overflow !== 1'b0 || rsp_underflow !== 1'b0 || req_ready !== 4'b0000) stable = 1'b0;
    end
    checks++; if (!stable) begin fails++; $display("FAIL bp_hold: got outputs changed or req_ready set expected stable response"); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++; if ({rsp_valid, req_ready} !== {1'b0, 4'b0001}) begin
      fails++; $display("FAIL bp_release: got valid=%b ready=%b expected 0 0001", rsp_valid, req_ready);
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_exec();
    bit acc, lat;
    bit quiet;
    int waited;
    do_op(1, 2'b00, 9'h0FF, 9'h010, 1'b0, acc, lat);
    checks++; if (err_count !== 8'd1) begin fails++; $display("FAIL rx_pre_err: got %0d expected 1", err_count); end
    release_rsp();
    req_a[2*DW +: DW] = 9'h018;
    req_b[2*DW +: DW] = 9'h018;
    req_op[5:4] = 2'b00;
    req_valid[2] = 1'b1;
    waited = 0;
    #1;
    while (req_ready[2] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checks++; if (waited >= 20) begin fails++; $display("FAIL rx_grant: got no grant expected grant to req 2"); end
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow, err_count, req_ready} !== '0) begin
      fails++; $display("FAIL rx_outputs: got valid=%b id=%0d res=%h ovf=%b unf=%b err=%0d ready=%b expected all 0",
                        rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_underflow, err_count, req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin fails++; $display("FAIL rx_no_response: got rsp_valid=1 expected 0"); end
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rx_fresh_grant: got %b expected 0001", req_ready); end
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_id} !== {1'b1, 2'd0}) begin
      fails++; $display("FAIL rx_fresh_rsp: got valid=%b id=%0d expected 1 0", rsp_valid, rsp_id);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_errors();
    test_err_clr();
    test_saturation();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
